// File: rtl/elastic_buffered_multiplexer.sv
// N-to-1 elastic multiplexer feeding a small output FIFO.
// Static mode forwards one configured channel; round-robin mode merges
// valid channels fairly starting after the last accepted one. Backpressure
// to the inputs comes only from registered FIFO state, so stop_output has
// no combinational path to stop_input.
module elastic_buffered_multiplexer #(
    parameter int DATA_WIDTH = 32,
    parameter int INPUT_NUM  = 5,
    parameter int SEL_WIDTH  = $clog2(INPUT_NUM),
    parameter int DEPTH      = 2,
    parameter int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [INPUT_NUM*DATA_WIDTH-1:0] data_input,
    input  logic [INPUT_NUM-1:0]            valid_input,
    output logic [INPUT_NUM-1:0]            stop_input,
    output logic [DATA_WIDTH-1:0]           data_output,
    output logic                            valid_output,
    input  logic                            stop_output,
    input  logic [SEL_WIDTH-1:0]            input_data_index,
    input  logic                            arbitrate,
    output logic [SEL_WIDTH-1:0]            grant_index,
    output logic                            grant_valid,
    output logic [CNT_WIDTH-1:0]            count
);

    localparam int PTR_WIDTH = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] channel_data [INPUT_NUM];
    logic [DATA_WIDTH-1:0] fifo_mem     [DEPTH];

    logic [CNT_WIDTH-1:0] count_reg, count_next;
    logic [PTR_WIDTH-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_WIDTH-1:0] rd_ptr_reg, rd_ptr_next;
    logic [SEL_WIDTH-1:0] rr_last_reg, rr_last_next;

    logic [SEL_WIDTH-1:0]  sel_index;
    logic                  sel_found;
    logic                  sel_valid;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  full;
    logic                  wr_en;
    logic                  rd_en;

    // Unpack the flat data bus into one entry per channel.
    genvar gi;
    generate
        for (gi = 0; gi < INPUT_NUM; gi++) begin : g_unpack
            assign channel_data[gi] = data_input[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Channel selection: static index (rejecting out-of-range values) or
    // round-robin scan beginning one past the last accepted channel.
    always_comb begin
        int cand;
        sel_index = '0;
        sel_found = 1'b0;
        cand      = 0;
        if (!arbitrate) begin
            if (int'(input_data_index) < INPUT_NUM) begin
                sel_index = input_data_index;
                sel_found = 1'b1;
            end
        end else begin
            for (int k = 1; k <= INPUT_NUM; k++) begin
                cand = int'(rr_last_reg) + k;
                if (cand >= INPUT_NUM) begin
                    cand = cand - INPUT_NUM;
                end
                if (!sel_found && valid_input[cand[SEL_WIDTH-1:0]]) begin
                    sel_index = cand[SEL_WIDTH-1:0];
                    sel_found = 1'b1;
                end
            end
        end
    end

    assign sel_valid = sel_found & valid_input[sel_index];
    assign sel_data  = channel_data[sel_index];

    assign full  = (count_reg == CNT_WIDTH'(DEPTH));
    assign wr_en = sel_valid & ~full;
    assign rd_en = (count_reg != '0) & ~stop_output;

    assign grant_index = sel_index;
    assign grant_valid = sel_found;

    // Only the granted channel may see stop low, and only while there is room.
    generate
        for (gi = 0; gi < INPUT_NUM; gi++) begin : g_stop
            assign stop_input[gi] = (sel_found && sel_index == SEL_WIDTH'(gi)) ? full : 1'b1;
        end
    endgenerate

    // Next-state for occupancy, pointers and round-robin history.
    always_comb begin
        count_next   = count_reg;
        wr_ptr_next  = wr_ptr_reg;
        rd_ptr_next  = rd_ptr_reg;
        rr_last_next = rr_last_reg;
        if (wr_en) begin
            wr_ptr_next = wr_ptr_reg + PTR_WIDTH'(1);
        end
        if (rd_en) begin
            rd_ptr_next = rd_ptr_reg + PTR_WIDTH'(1);
        end
        if (wr_en && !rd_en) begin
            count_next = count_reg + CNT_WIDTH'(1);
        end else if (rd_en && !wr_en) begin
            count_next = count_reg - CNT_WIDTH'(1);
        end
        if (wr_en && arbitrate) begin
            rr_last_next = sel_index;
        end
    end

    // Control state; reset drops all buffered entries and primes channel 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg   <= '0;
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            rr_last_reg <= SEL_WIDTH'(INPUT_NUM - 1);
        end else begin
            count_reg   <= count_next;
            wr_ptr_reg  <= wr_ptr_next;
            rd_ptr_reg  <= rd_ptr_next;
            rr_last_reg <= rr_last_next;
        end
    end

    // FIFO storage; contents are only meaningful where count says so.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            fifo_mem[wr_ptr_reg] <= sel_data;
        end
    end

    assign valid_output = (count_reg != '0);
    assign data_output  = valid_output ? fifo_mem[rd_ptr_reg] : '0;
    assign count        = count_reg;

endmodule

// File: tb/tb_elastic_buffered_multiplexer.sv
// Scoreboard bench for elastic_buffered_multiplexer (5 channels, depth 2).
// A cycle model predicts grants, stops and occupancy; accepted words are
// queued and compared in order as the FIFO pops them.
module tb_elastic_buffered_multiplexer;

    localparam int DW    = 32;
    localparam int N     = 5;
    localparam int SW    = $clog2(N);
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic            clk;
    logic            reset_n;
    logic [N*DW-1:0] data_input;
    logic [N-1:0]    valid_input;
    logic [N-1:0]    stop_input;
    logic [DW-1:0]   data_output;
    logic            valid_output;
    logic            stop_output;
    logic [SW-1:0]   input_data_index;
    logic            arbitrate;
    logic [SW-1:0]   grant_index;
    logic            grant_valid;
    logic [CW-1:0]   count;

    logic [DW-1:0] chan_data [N];
    logic [DW-1:0] sb_queue [$];
    int            m_count;
    int            m_rr;
    int            n_checks;
    int            n_errors;

    elastic_buffered_multiplexer #(
        .DATA_WIDTH(DW), .INPUT_NUM(N), .SEL_WIDTH(SW), .DEPTH(DEPTH), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .data_input(data_input), .valid_input(valid_input), .stop_input(stop_input),
        .data_output(data_output), .valid_output(valid_output), .stop_output(stop_output),
        .input_data_index(input_data_index), .arbitrate(arbitrate),
        .grant_index(grant_index), .grant_valid(grant_valid), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        data_input = '0;
        for (int i = 0; i < N; i++) data_input[i*DW +: DW] = chan_data[i];
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_count = 0;
        m_rr    = N - 1;
        sb_queue.delete();
    endtask

    // One clock: check combinational outputs against the model, then advance.
    task automatic step();
        int       g;
        bit       gv;
        bit       full;
        bit       acc;
        bit       pop;
        logic [N-1:0]  exp_stop;
        logic [DW-1:0] exp_d;
        #1;
        g  = 0;
        gv = 0;
        if (!arbitrate) begin
            if (int'(input_data_index) < N) begin
                g  = int'(input_data_index);
                gv = 1;
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_rr + k) % N;
                if (!gv && valid_input[c]) begin
                    g  = c;
                    gv = 1;
                end
            end
        end
        full     = (m_count == DEPTH);
        exp_stop = '1;
        if (gv) exp_stop[g] = full;
        check_val("grant_valid", 32'(grant_valid), 32'(gv));
        check_val("grant_index", 32'(grant_index), 32'(g));
        check_val("stop_input", 32'(stop_input), 32'(exp_stop));
        check_val("count", 32'(count), 32'(m_count));
        check_val("valid_output", 32'(valid_output), 32'(m_count != 0));
        if (m_count == 0) begin
            check_val("data_output_empty", data_output, 32'h0);
        end
        acc = gv && valid_input[g] && !full;
        pop = (m_count != 0) && !stop_output;
        if (pop) begin
            exp_d = sb_queue.pop_front();
            check_val("pop_data", data_output, exp_d);
            $display("t=%0t pop  data=0x%0h expected=0x%0h", $time, data_output, exp_d);
        end
        if (acc) begin
            sb_queue.push_back(chan_data[g]);
            $display("t=%0t push ch=%0d data=0x%0h", $time, g, chan_data[g]);
        end
        @(posedge clk);
        #1;
        m_count = m_count + int'(acc) - int'(pop);
        if (acc) begin
            if (arbitrate) m_rr = g;
            chan_data[g] = chan_data[g] + 1;
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        model_reset();
        for (int i = 0; i < N; i++) chan_data[i] = 32'h1000 * (i + 1);
        reset_n          = 1'b0;
        valid_input      = '0;
        stop_output      = 1'b0;
        input_data_index = '0;
        arbitrate        = 1'b0;

        // Reset state
        #12;
        check_val("rst_valid_output", 32'(valid_output), 32'h0);
        check_val("rst_count", 32'(count), 32'h0);
        check_val("rst_data_output", data_output, 32'h0);
        check_val("rst_stop_input", 32'(stop_input), 32'h1e);
        reset_n = 1'b1;
        step();

        // Static pass-through on channel 2
        chan_data[2]     = 32'hA0;
        input_data_index = 3'd2;
        valid_input      = 5'b00100;
        for (int i = 0; i < 8; i++) step();

        // Backpressure fill, single pop, refill, then drain
        stop_output = 1'b1;
        for (int i = 0; i < 3; i++) step();
        stop_output = 1'b0;
        step();
        stop_output = 1'b1;
        for (int i = 0; i < 2; i++) step();
        valid_input = '0;
        stop_output = 1'b0;
        for (int i = 0; i < 3; i++) step();

        // Round-robin fairness over channels 0, 1, 3, then channel 3 alone
        arbitrate   = 1'b1;
        valid_input = 5'b01011;
        for (int i = 0; i < 9; i++) step();
        valid_input = 5'b01000;
        for (int i = 0; i < 4; i++) step();

        // Out-of-range static index with every channel valid
        valid_input = '0;
        for (int i = 0; i < 3; i++) step();
        arbitrate        = 1'b0;
        input_data_index = 3'd7;
        valid_input      = 5'b11111;
        for (int i = 0; i < 3; i++) step();

        // Fill to two, then reset between clock edges
        input_data_index = 3'd1;
        stop_output      = 1'b1;
        for (int i = 0; i < 3; i++) step();
        #2;
        reset_n = 1'b0;
        #1;
        check_val("midrst_valid_output", 32'(valid_output), 32'h0);
        check_val("midrst_count", 32'(count), 32'h0);
        check_val("midrst_data_output", data_output, 32'h0);
        model_reset();
        #2;
        reset_n     = 1'b1;
        stop_output = 1'b0;
        arbitrate   = 1'b1;
        valid_input = 5'b11111;
        for (int i = 0; i < 6; i++) step();

        // Mode switch with an entry buffered from static channel 4
        valid_input = '0;
        for (int i = 0; i < 3; i++) step();
        arbitrate        = 1'b0;
        input_data_index = 3'd4;
        chan_data[4]     = 32'h44;
        valid_input      = 5'b10000;
        stop_output      = 1'b1;
        step();
        arbitrate   = 1'b1;
        valid_input = 5'b11111;
        stop_output = 1'b0;
        for (int i = 0; i < 8; i++) step();
        valid_input = '0;
        for (int i = 0; i < 3; i++) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/elastic_buffered_multiplexer.md
Name: elastic_buffered_multiplexer

Overview:
Parametrised N-to-1 elastic multiplexer with a registered output FIFO, used on PE input ports of the elastic CGRA. It supports two modes. In static mode, the configured index selects one input. In round-robin mode, it merges whichever inputs are valid. Only the granted input sees stop deasserted. Stop is produced from registered FIFO state, so there is no combinational path from stop_output to stop_input.

Parameters:
DATA_WIDTH, 32, width of each data channel
INPUT_NUM, 5, number of input channels (>=2)
SEL_WIDTH, $clog2(INPUT_NUM), width of input_data_index and grant_index
DEPTH, 2, output FIFO entries (power of two, >=2)
CNT_WIDTH, $clog2(DEPTH)+1, width of occupancy count

Ports:
clk  input  1  clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
data_input  input  INPUT_NUM*DATA_WIDTH  channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
valid_input  input  INPUT_NUM  per-channel valid
stop_input  output  INPUT_NUM  per-channel backpressure (1 = not accepting)
data_output  output  DATA_WIDTH  FIFO head data
valid_output  output  1  FIFO non-empty
stop_output  input  1  downstream backpressure
input_data_index  input  SEL_WIDTH  static-mode channel select
arbitrate  input  1  0 = static mode, 1 = round-robin mode
grant_index  output  SEL_WIDTH  channel selected this cycle (combinational)
grant_valid  output  1  a channel is selected this cycle
count  output  CNT_WIDTH  FIFO occupancy

Behaviour:
- Transfer rule, both sides: a transfer occurs in a cycle where valid=1 and stop=0.
- Selection, static mode (arbitrate=0):
  - grant_index = input_data_index; grant_valid = 1.
  - If input_data_index >= INPUT_NUM: grant_valid = 0, grant_index = 0, all stop_input = 1, nothing accepted.
- Selection, round-robin mode (arbitrate=1):
  - Scan starts at rr_last+1, wraps modulo INPUT_NUM, and picks the first i with valid_input[i] = 1.
  - If no input is valid: grant_valid = 0, grant_index = 0.
- Backpressure:
  - full = (count == DEPTH).
  - stop_input[i] = 1 for every i != grant_index, or when grant_valid = 0.
  - stop_input[grant_index] = full.
- Write (accept) = grant_valid & valid_input[grant_index] & !full. Pushes the selected data at wr_ptr.
- Read = valid_output & !stop_output. Pops the head.
- Simultaneous write and read: count is unchanged and both pointers advance.
- When full, a same-cycle read does not enable a write; the write proceeds the next cycle.
- Empty FIFO: valid_output = 0 and data_output = 0. There is no bypass, so minimum latency from input to output is 1 cycle.
- Pointers are log2(DEPTH) bits and wrap naturally.
- count increments on write-only, decrements on read-only, and never exceeds DEPTH or underflows.
- rr_last updates to grant_index only on an accepted write; in static mode rr_last holds its value.
- Mode and index may change on any cycle, with combinational effect. Already-buffered entries are unaffected.
- Reset (asynchronous, reset_n = 0):
  - count = 0, wr_ptr = rd_ptr = 0, rr_last = INPUT_NUM-1 (first priority goes to channel 0).
  - Outputs: valid_output = 0, data_output = 0. stop_input, grant_index and grant_valid follow the combinational rules with count = 0.
- Reset mid-operation discards all buffered data.
- FIFO storage needs no reset.

Test Plan:
- Static pass-through: arbitrate=0, index=2, valid_input[2] held 1 with data 0xA0, 0xA1, …, stop_output=0 → valid_output rises 1 cycle after the first accept, outputs 0xA0, 0xA1, … one per cycle; stop_input = 5'b11011 throughout.
- Backpressure fill: DEPTH=2, stop_output=1, channel 2 streaming → count reaches 2 after 2 cycles and stop_input[2]=1. Then drop stop_output for 1 cycle → one pop, count=1; the next write occurs the following cycle; no data is lost or duplicated.
- Round-robin fairness: arbitrate=1, channels 0, 1 and 3 all valid continuously, stop_output=0 → grant sequence 0,1,3,0,1,3…. When only channel 3 is valid, it is granted every cycle.
- Invalid index: arbitrate=0, index=7 with all inputs valid → stop_input=5'b11111, grant_valid=0, count stays 0.
- Reset mid-stream: with count=2 and valid_output=1, assert reset_n=0 asynchronously between clock edges → valid_output=0 and count=0 immediately. After release, round-robin grants channel 0 first when all inputs are valid.
- Mode switch: switch from static index 4 to round-robin while the FIFO holds 0x44 → 0x44 is still delivered first, then the round-robin order starts after rr_last (unchanged by static mode).
